// File: rtl/npu_job_driver_pkg.sv
// npu_job_defs: shared state encodings and constants for the NPU job driver
package npu_job_defs;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;
  localparam logic [7:0] TIMEOUT_CODE_DEF = 8'hFF;
  localparam int SSFR_DBG_BIT = 0;
endpackage

// File: rtl/npu_timeout_cnt.sv
// npu_timeout_cnt: saturating 8-bit cycle counter with clear, enable and terminal-count flag
module npu_timeout_cnt #(
  parameter logic [7:0] TC = 8'd63
) (
  input  logic CLKEXT,
  input  logic RST_GLO,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  always_ff @(posedge CLKEXT)
    cnt <= (RST_GLO || clr) ? 8'd0 : (en && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
  assign tc = cnt == TC;
endmodule

// File: rtl/npu_job_driver.sv
// npu_job_driver: host-side NPU job initiator; timeout path built only with NPU_JOB_DRIVER_TIMEOUT_EN
module npu_job_driver
  import npu_job_defs::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] TIMEOUT_CODE   = TIMEOUT_CODE_DEF
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO,
  input  logic        JOB_VALID,
  output logic        JOB_READY,
  input  logic [7:0]  JOB_DA,
  input  logic [7:0]  JOB_DB,
  input  logic [7:0]  JOB_DC,
  input  logic [7:0]  JOB_DD,
  input  logic [7:0]  JOB_BIAS,
  input  logic        JOB_DEBUG,
  output logic        START,
  output logic [7:0]  DA,
  output logic [7:0]  DB,
  output logic [7:0]  DC,
  output logic [7:0]  DD,
  output logic [7:0]  BIAS_IN,
  output logic [15:0] SSFR,
  input  logic        NPU_BUSY,
  input  logic        NPU_DONE,
  input  logic [7:0]  NPU_DOUT,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [7:0]  RES_DATA,
  output logic        RES_TIMEOUT
);
  state_t state, state_nx;
  logic   tc_hit, accept, finish, unused_in;
`ifdef NPU_JOB_DRIVER_TIMEOUT_EN
  logic tc;
  npu_timeout_cnt #(.TC(8'(TIMEOUT_CYCLES - 1))) u_cnt (
    .CLKEXT (CLKEXT),
    .RST_GLO(RST_GLO),
    .clr    (state != WAIT_DONE),
    .en     (state == WAIT_DONE),
    .tc     (tc)
  );
  assign tc_hit    = tc;
  assign unused_in = NPU_BUSY;
`else
  assign tc_hit    = 1'b0;
  assign unused_in = ^{NPU_BUSY, TIMEOUT_CYCLES[7:0]};
`endif
  assign accept = state == IDLE && JOB_VALID;
  assign finish = state == WAIT_DONE && (NPU_DONE || tc_hit);
  always_ff @(posedge CLKEXT)
    state <= RST_GLO ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE)  ? (accept ? ISSUE : IDLE) :
               (state == ISSUE) ? WAIT_DONE :
               (state == WAIT_DONE) ? (finish ? RESP : WAIT_DONE) :
               (RES_READY ? IDLE : RESP);
  always_comb begin
    JOB_READY = state == IDLE && !RST_GLO;
    START     = state == ISSUE;
    RES_VALID = state == RESP;
  end
  always_ff @(posedge CLKEXT)
    if (RST_GLO) begin
      DA          <= 8'd0;
      DB          <= 8'd0;
      DC          <= 8'd0;
      DD          <= 8'd0;
      BIAS_IN     <= 8'd0;
      SSFR        <= 16'd0;
      RES_DATA    <= 8'd0;
      RES_TIMEOUT <= 1'b0;
    end else begin
      if (accept) begin
        DA      <= JOB_DA;
        DB      <= JOB_DB;
        DC      <= JOB_DC;
        DD      <= JOB_DD;
        BIAS_IN <= JOB_BIAS;
        SSFR    <= 16'(JOB_DEBUG) << SSFR_DBG_BIT;
      end
      if (finish) begin
        RES_DATA    <= NPU_DONE ? NPU_DOUT : TIMEOUT_CODE;
        RES_TIMEOUT <= tc_hit && !NPU_DONE;
      end
    end
endmodule

// File: tb/tb_npu_job_driver.sv
// tb_npu_job_driver: randomized directed bench for npu_job_driver against a job-level reference model
module tb_npu_job_driver;
  localparam int TO = 16;
`ifdef NPU_JOB_DRIVER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic        CLKEXT = 1'b0;
  logic        RST_GLO, JOB_VALID, JOB_READY, JOB_DEBUG, START;
  logic [7:0]  JOB_DA, JOB_DB, JOB_DC, JOB_DD, JOB_BIAS;
  logic [7:0]  DA, DB, DC, DD, BIAS_IN, NPU_DOUT, RES_DATA;
  logic [15:0] SSFR;
  logic        NPU_BUSY, NPU_DONE, RES_VALID, RES_READY, RES_TIMEOUT;
  logic [55:0] lanes_o;
  int          tests = 0;
  int          fails = 0;
  assign lanes_o = {DA, DB, DC, DD, BIAS_IN, SSFR};
  always #5 CLKEXT = ~CLKEXT;
  npu_job_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
    .JOB_DA(JOB_DA), .JOB_DB(JOB_DB), .JOB_DC(JOB_DC), .JOB_DD(JOB_DD),
    .JOB_BIAS(JOB_BIAS), .JOB_DEBUG(JOB_DEBUG), .START(START),
    .DA(DA), .DB(DB), .DC(DC), .DD(DD), .BIAS_IN(BIAS_IN), .SSFR(SSFR),
    .NPU_BUSY(NPU_BUSY), .NPU_DONE(NPU_DONE), .NPU_DOUT(NPU_DOUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_TIMEOUT(RES_TIMEOUT)
  );
  task automatic tick;
    @(posedge CLKEXT);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_start"}, 64'(START), 64'd0);
    check({tag, "_lanes"}, 64'(lanes_o), 64'd0);
    check({tag, "_valid"}, 64'(RES_VALID), 64'd0);
    check({tag, "_data"}, 64'(RES_DATA), 64'd0);
    check({tag, "_tmo"}, 64'(RES_TIMEOUT), 64'd0);
    check({tag, "_ready"}, 64'(JOB_READY), 64'd1);
  endtask
  // Model: the NPU raises DONE k cycles after the START cycle. With the timeout
  // built in, WAIT_DONE lasts at most TO cycles, so any k beyond TO yields a timeout.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] bias, input logic dbg,
                         input int k, input logic [7:0] dout, input int hold);
    logic [55:0] lanes;
    logic        to;
    logic [7:0]  rd;
    int          end_t;
    lanes = {a, b, c, d, bias, 15'd0, dbg};
    to    = TO_EN && k > TO;
    end_t = to ? TO : k;
    rd    = to ? 8'hFF : dout;
    JOB_DA = a; JOB_DB = b; JOB_DC = c; JOB_DD = d; JOB_BIAS = bias; JOB_DEBUG = dbg;
    JOB_VALID = 1'b1;
    RES_READY = hold == 0;
    check("job_ready_idle", 64'(JOB_READY), 64'd1);
    tick;
    JOB_VALID = 1'b0;
    JOB_DA = 8'($urandom); JOB_DB = 8'($urandom); JOB_DC = 8'($urandom);
    JOB_DD = 8'($urandom); JOB_BIAS = 8'($urandom); JOB_DEBUG = 1'($urandom);
    check("start_issue", 64'(START), 64'd1);
    check("lanes_issue", 64'(lanes_o), 64'(lanes));
    tick;
    for (int t = 1; t <= end_t; t++) begin
      JOB_VALID = 1'($urandom_range(0, 1));
      NPU_BUSY  = 1'b1;
      NPU_DONE  = t == k;
      NPU_DOUT  = (t == k) ? dout : 8'($urandom);
      check("start_low", 64'(START), 64'd0);
      check("lanes_wait", 64'(lanes_o), 64'(lanes));
      check("no_valid_wait", 64'(RES_VALID), 64'd0);
      check("not_ready_wait", 64'(JOB_READY), 64'd0);
      tick;
    end
    NPU_DONE = 1'b0;
    NPU_BUSY = 1'b0;
    check("res_valid", 64'(RES_VALID), 64'd1);
    check("res_data", 64'(RES_DATA), 64'(rd));
    check("res_timeout", 64'(RES_TIMEOUT), 64'(to));
    check("lanes_resp", 64'(lanes_o), 64'(lanes));
    for (int h = 1; h < hold; h++) begin
      NPU_DONE  = 1'($urandom_range(0, 1));
      NPU_DOUT  = 8'($urandom);
      JOB_VALID = 1'($urandom_range(0, 1));
      tick;
      check("hold_valid", 64'(RES_VALID), 64'd1);
      check("hold_data", 64'(RES_DATA), 64'(rd));
      check("hold_timeout", 64'(RES_TIMEOUT), 64'(to));
      check("hold_start", 64'(START), 64'd0);
    end
    NPU_DONE  = 1'b0;
    JOB_VALID = 1'b0;
    RES_READY = 1'b1;
    tick;
    RES_READY = 1'b0;
    check("valid_after_hs", 64'(RES_VALID), 64'd0);
    check("ready_after_hs", 64'(JOB_READY), 64'd1);
    check("lanes_idle", 64'(lanes_o), 64'(lanes));
  endtask
  initial begin
    RST_GLO = 1'b1; JOB_VALID = 1'b0; JOB_DEBUG = 1'b0; RES_READY = 1'b0;
    JOB_DA = 8'd0; JOB_DB = 8'd0; JOB_DC = 8'd0; JOB_DD = 8'd0; JOB_BIAS = 8'd0;
    NPU_BUSY = 1'b0; NPU_DONE = 1'b0; NPU_DOUT = 8'd0;
    #1;
    check("ready_in_reset", 64'(JOB_READY), 64'd0);
    tick;
    tick;
    check("ready_in_reset2", 64'(JOB_READY), 64'd0);
    RST_GLO = 1'b0;
    #1;
    check_reset("por");
    run_job(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b0, 12, 8'h2A, 0);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, TO_EN ? 1000 : 40, 8'($urandom), 0);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, $urandom_range(1, 10), 8'($urandom), 5);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b1, $urandom_range(1, 10), 8'($urandom), 2);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, $urandom_range(1, 10), 8'($urandom), 1);
    JOB_DA = 8'($urandom); JOB_DB = 8'($urandom); JOB_DC = 8'($urandom);
    JOB_DD = 8'($urandom); JOB_BIAS = 8'($urandom); JOB_DEBUG = 1'b1;
    JOB_VALID = 1'b1;
    tick;
    JOB_VALID = 1'b0;
    tick;
    tick;
    tick;
    RST_GLO = 1'b1;
    #1;
    check("ready_mid_reset", 64'(JOB_READY), 64'd0);
    tick;
    RST_GLO = 1'b0;
    #1;
    check_reset("mid_job_reset");
    NPU_DONE = 1'b1;
    NPU_DOUT = 8'($urandom);
    tick;
    NPU_DONE = 1'b0;
    check("late_done_ignored", 64'(RES_VALID), 64'd0);
    check("late_done_ready", 64'(JOB_READY), 64'd1);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, $urandom_range(1, 10), 8'($urandom), 0);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b0, TO, 8'($urandom), 0);
    run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'b1, 1, 8'($urandom), 0);
    for (int j = 0; j < 8; j++)
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(1, TO + 8), 8'($urandom),
              $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
